// File: rtl/cpu_debug_cmd_sync_pkg.sv
// cpu_debug_pkg: IR codes, command record and one-hot helper for the debug command path
package cpu_debug_pkg;

    localparam int unsigned IR_OCIMEM    = 0;
    localparam int unsigned IR_TRACEMEM  = 1;
    localparam int unsigned IR_BREAK     = 2;
    localparam int unsigned IR_TRACECTRL = 3;

    localparam int DEF_IR_W   = 2;
    localparam int DEF_SR_W   = 38;
    localparam int MAX_NUM_IR = 16;

    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] sr;
    } debug_cmd_t;

    function automatic logic [MAX_NUM_IR-1:0] ir_onehot(input int unsigned code);
        return MAX_NUM_IR'(1) << code;
    endfunction

endpackage

// File: rtl/cpu_debug_cmd_sync_if.sv
// cpu_debug_cmd_sync_if: command handshake and decoded pulses towards the CPU debug logic
interface cpu_debug_cmd_sync_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IR_W-1:0]      cmd_ir;
    logic [SR_W-1:0]      jdo;
    logic [2**IR_W-1:0]   take_action;
    logic [2**IR_W-1:0]   take_no_action;

    modport master (
        output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/cpu_debug_cmd_sync_strobe_sync.sv
// cpu_debug_strobe_sync: synchronise an async level, emit a registered rise pulse masked during warm-up
module cpu_debug_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] WARM = CW'(STAGES + 1);

    logic [STAGES-1:0] sync;
    logic              dly;
    logic [CW-1:0]     warm;

    // sync chain, edge-detect delay flop and warm-up counter that hides levels already high at release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            dly  <= 1'b0;
            warm <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            dly  <= sync[STAGES-1];
            warm <= (warm == WARM) ? warm : warm + CW'(1);
            rise <= sync[STAGES-1] & ~dly & (warm == WARM);
        end
    end
endmodule

// File: rtl/cpu_debug_cmd_sync.sv
// cpu_debug_cmd_sync: capture JTAG update-DR commands into a FIFO and decode pops into take pulses
module cpu_debug_cmd_sync
    import cpu_debug_pkg::*;
#(
    parameter int SR_W         = 38,
    parameter int IR_W         = 2,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int ACT_BIT      = 35,
    parameter bit FLUSH_ON_UIR = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [SR_W-1:0]        sr,
    input  logic                   clr_overflow,
    output logic                   uir_pulse,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    cpu_debug_cmd_sync_if.master   cmd
);
    localparam int NUM_IR = 2**IR_W;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr, rd;
    logic        udr_rise, uir_rise, full, pop, flush, push, drop;

    cpu_debug_strobe_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
        .clk, .reset_n, .d(vs_udr), .rise(udr_rise)
    );

    cpu_debug_strobe_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
        .clk, .reset_n, .d(vs_uir), .rise(uir_rise)
    );

    assign head          = mem[rd[AW-1:0]];
    assign cmd.cmd_valid = wr != rd;
    assign cmd.cmd_ir    = cmd.cmd_valid ? head.ir : '0;
    assign level         = wr - rd;

    // a flush wins over a same-cycle push; a full queue only takes a push when it is also popping
    always_comb begin
        full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
        pop   = cmd.cmd_valid & cmd.cmd_ready;
        flush = FLUSH_ON_UIR & uir_rise;
        push  = udr_rise & ~flush & (~full | pop);
        drop  = udr_rise & ~flush & full & ~pop;
    end

    // storage is not reset; the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= '{ir: ir_in, sr: sr};
    end

    // pointers, held jdo, one-cycle decode pulses and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr                 <= '0;
            rd                 <= '0;
            cmd.jdo            <= '0;
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
            uir_pulse          <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            wr                 <= wr + (AW+1)'(push);
            rd                 <= flush ? wr : rd + (AW+1)'(pop);
            cmd.jdo            <= pop ? head.sr : cmd.jdo;
            cmd.take_action    <= (pop && head.sr[ACT_BIT]) ? NUM_IR'(ir_onehot(int'(head.ir))) : '0;
            cmd.take_no_action <= (pop && !head.sr[ACT_BIT]) ? NUM_IR'(ir_onehot(int'(head.ir))) : '0;
            uir_pulse          <= uir_rise;
            overflow           <= drop | (overflow & ~clr_overflow);
        end
    end
endmodule

// File: tb/tb_cpu_debug_cmd_sync.sv
// tb_cpu_debug_cmd_sync: directed scenarios plus random traffic checked against a queue-based model
module tb_cpu_debug_cmd_sync;
    import cpu_debug_pkg::*;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        vs_udr = 0;
    logic        vs_uir = 0;
    logic [1:0]  ir_in = 0;
    logic [37:0] sr = 0;
    logic        clr_overflow = 0;
    logic        uir_pulse;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    cpu_debug_cmd_sync_if #(.SR_W(38), .IR_W(2)) cmd ();

    cpu_debug_cmd_sync dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .clr_overflow(clr_overflow),
        .uir_pulse(uir_pulse), .level(level), .overflow(overflow), .cmd(cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a strobe level first seen high at edge k (low at edge k-1) yields its
    // event at edge k+3, provided that edge lies beyond the warm-up window (edge index >= 4).
    debug_cmd_t  q[$];
    logic [3:0]  hu = 0, hi = 0;
    int          p = 0;
    bit          ov = 0, e_uir = 0;
    logic [3:0]  e_act = 0, e_na = 0;
    logic [37:0] e_jdo = 0;

    always @(posedge clk or negedge reset_n) begin
        bit up, ui;
        debug_cmd_t h;
        if (!reset_n) begin
            q.delete();
            hu = 0; hi = 0; p = 0; ov = 0; e_uir = 0; e_act = 0; e_na = 0; e_jdo = 0;
        end else begin
            up = p >= 4 && hu[2] && !hu[3];
            ui = p >= 4 && hi[2] && !hi[3];
            e_act = 0;
            e_na = 0;
            if (q.size() > 0 && cmd.cmd_ready) begin
                h = q.pop_front();
                e_jdo = h.sr;
                if (h.sr[35]) e_act = 4'(1) << h.ir;
                else e_na = 4'(1) << h.ir;
            end
            e_uir = ui;
            if (ui) q.delete();
            if (up && !ui && q.size() >= 4) ov = 1;
            else if (clr_overflow) ov = 0;
            if (up && !ui && q.size() < 4) q.push_back(debug_cmd_t'{ir: ir_in, sr: sr});
            hu = {hu[2:0], vs_udr};
            hi = {hi[2:0], vs_uir};
            if (p < 1000) p++;
        end
    end

    always @(negedge clk) begin
        check("cmd_valid", 64'(cmd.cmd_valid), 64'(q.size() > 0));
        check("level", 64'(level), 64'(q.size()));
        check("cmd_ir", 64'(cmd.cmd_ir), 64'(q.size() > 0 ? q[0].ir : 2'd0));
        check("jdo", 64'(cmd.jdo), 64'(e_jdo));
        check("take_action", 64'(cmd.take_action), 64'(e_act));
        check("take_no_action", 64'(cmd.take_no_action), 64'(e_na));
        check("uir_pulse", 64'(uir_pulse), 64'(e_uir));
        check("overflow", 64'(overflow), 64'(ov));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] i, input logic [37:0] s);
        ir_in = i;
        sr = s;
        vs_udr = 1;
        tick(5);
        vs_udr = 0;
        tick(2);
    endtask

    initial begin
        cmd.cmd_ready = 0;
        tick(3);
        reset_n = 1;
        tick(6);

        cmd.cmd_ready = 1;
        strobe(2'd2, 38'h2A_0000_0001);
        check("latency_jdo", 64'(cmd.jdo), 64'h2A_0000_0001);

        cmd.cmd_ready = 0;
        strobe(2'd0, 38'h01_2345_6789);
        strobe(2'd1, 38'h00_0000_00FF);
        strobe(2'd3, 38'h30_ABCD_0000);
        check("order_level", 64'(level), 64'd3);
        cmd.cmd_ready = 1;
        tick(4);
        check("order_drained", 64'(level), 64'd0);

        cmd.cmd_ready = 0;
        for (int k = 0; k < 5; k++) strobe(2'(k), {1'b0, k[0], 36'(k)});
        check("ovf_level", 64'(level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        clr_overflow = 1;
        tick(1);
        clr_overflow = 0;
        check("ovf_clear", 64'(overflow), 64'd0);

        ir_in = 2'd1;
        sr = 38'h08_0000_0042;
        vs_udr = 1;
        tick(3);
        cmd.cmd_ready = 1;
        tick(1);
        cmd.cmd_ready = 0;
        vs_udr = 0;
        tick(2);
        check("full_pop_level", 64'(level), 64'd4);
        check("full_pop_ovf", 64'(overflow), 64'd0);

        cmd.cmd_ready = 1;
        tick(6);
        cmd.cmd_ready = 0;
        strobe(2'd2, 38'h08_0000_0001);
        strobe(2'd3, 38'h00_0000_0002);
        check("flush_pre", 64'(level), 64'd2);
        vs_uir = 1;
        tick(5);
        vs_uir = 0;
        tick(2);
        check("flush_level", 64'(level), 64'd0);
        check("flush_valid", 64'(cmd.cmd_valid), 64'd0);

        vs_udr = 1;
        reset_n = 0;
        tick(2);
        reset_n = 1;
        tick(6);
        check("warm_nopush", 64'(level), 64'd0);
        vs_udr = 0;
        tick(2);
        strobe(2'd0, 38'h11);
        check("warm_onepush", 64'(level), 64'd1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(40) == 0) vs_uir = ~vs_uir;
            cmd.cmd_ready = $urandom_range(2) == 0;
            clr_overflow = $urandom_range(7) == 0;
            ir_in = 2'($urandom());
            sr = 38'({$urandom(), $urandom()});
            if ($urandom_range(999) == 0) begin
                reset_n = 0;
                tick(1);
                reset_n = 1;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_debug_cmd_sync.md
Name: cpu_debug_cmd_sync

Overview:
System-clock half of the CPU debug slave, generalised. It synchronises update-DR/update-IR strobes from the JTAG TCK domain and captures {ir_in, sr} on each update-DR. Captured commands queue in a small FIFO. Each popped command is decoded into per-IR one-cycle take_action / take_no_action pulses plus a held jdo word for the CPU debug logic. Width, IR size, FIFO depth and synchroniser depth are parameters; queueing, overflow reporting and UIR flush are new.

Parameters:
SR_W, 38, shift-register / jdo width
IR_W, 2, instruction register width; NUM_IR = 2**IR_W
DEPTH, 4, command FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, synchroniser flops on vs_udr/vs_uir (>=2)
ACT_BIT, 35, sr bit selecting action (1) vs no-action (0)
FLUSH_ON_UIR, 1, 1 = update-IR edge discards queued commands

Ports:
clk  in  1  system clock
reset_n  in  1  reset
vs_udr  in  1  update-DR level from TCK domain (async)
vs_uir  in  1  update-IR level from TCK domain (async)
ir_in  in  IR_W  JTAG IR; stable while vs_udr high
sr  in  SR_W  TCK shift register; stable while vs_udr high
cmd_ready  in  1  consumer accepts head command
clr_overflow  in  1  clears overflow flag
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_W  head entry IR
jdo  out  SR_W  sr of most recently popped command (held)
take_action  out  NUM_IR  one-hot pulse, popped ir, ACT_BIT=1
take_no_action  out  NUM_IR  one-hot pulse, popped ir, ACT_BIT=0
uir_pulse  out  1  one-cycle pulse per synchronised vs_uir rise
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a push was dropped

Behaviour:
- One clock, clk. reset_n is asynchronous, active-low.
- Reset values: all outputs 0, FIFO empty, sync chains 0, warm-up counter 0.
- Synchroniser: per strobe, SYNC_STAGES flops then a delay flop. rise = last stage & ~delay.
- Warm-up: a counter masks rise for SYNC_STAGES+1 cycles after reset release. A level already high at release therefore produces no push and no uir_pulse.
- Push latency: vs_udr rises before clk edge 0. The push occurs at edge SYNC_STAGES+1, and cmd_valid is high after that edge. {ir_in, sr} are sampled at the push edge. There is no bypass path.
- Pop: handshake = cmd_valid & cmd_ready at an edge. At that edge, jdo <= head sr, and the read pointer advances.
  - If head sr[ACT_BIT]=1, take_action[head ir] is high for exactly the following cycle.
  - Otherwise take_no_action[head ir] is high for that cycle.
  - Never more than one bit across both vectors is set.
- Full: a push while full with no pop is dropped, FIFO unchanged, overflow <= 1.
- Full with simultaneous pop: the push is accepted and level is unchanged.
- Empty with push: there is no pop that cycle, since cmd_valid is still 0.
- Pointers: wrap modulo DEPTH with an extra MSB for full/empty. level = wr - rd.
- overflow: set by a dropped push, cleared by clr_overflow. Set wins if both occur in the same cycle.
- uir rise: uir_pulse is high for one cycle.
  - If FLUSH_ON_UIR=1, at the same edge the FIFO empties (rd <= wr), and any simultaneous udr push is also discarded. A pop in that cycle still completes and pulses.
  - If FLUSH_ON_UIR=0, the queue is untouched.
- Reset mid-operation: queue, pulses, jdo and overflow clear immediately. The warm-up counter restarts.

Decomposition:
- Package cpu_debug_pkg holds:
  - IR code constants: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Typedef debug_cmd_t {ir, sr}.
  - A function returning the one-hot vector for an IR code.
- Sub-module cpu_debug_strobe_sync: parameterised synchroniser, delay flop and warm-up mask. It outputs the rise pulse and is instantiated twice.
- The FIFO is inline.

Test Plan:
- Push latency: defaults; wait >3 cycles after reset, then raise vs_udr with ir=2, sr[35]=1, sr=38'h2A_0000_0001 -> cmd_valid high after edge 3, cmd_ir=2. With cmd_ready=1, jdo=38'h2A_0000_0001 and take_action=4'b0100 for one cycle.
- No-action and FIFO ordering: 3 udr strobes (ir 0,1,3; sr[35]=0) with cmd_ready=0 -> level=3. Then pop -> take_no_action pulses 0001, 0010, 1000 in order.
- Overflow: 5 strobes with cmd_ready=0 -> level=4, overflow=1, the 5th entry lost. Then clr_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full, cmd_ready=1 while a push arrives -> level stays 4, overflow stays 0.
- UIR flush: 2 queued entries, then raise vs_uir -> uir_pulse for 1 cycle, level=0, cmd_valid=0, no take pulses.
- Reset warm-up: hold vs_udr=1 through reset release -> no push, level=0. Then drop and re-raise vs_udr -> exactly 1 push.
